// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fifo
//  Description : Byte buffer between uart_rx and uart_tx in the RS-485
//                loopback path. It drops framing-error bytes and counts them,
//                queues good bytes in a FIFO, and drains the FIFO into
//                uart_tx using the transmitter's busy/done handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    // Receiver side
    input  logic [WIDTH-1:0]         rx_data,
    input  logic                     rx_done,
    input  logic                     frame_error,
    // Transmitter side
    input  logic                     tx_busy,
    input  logic                     tx_done,
    output logic                     tx_start,
    output logic [WIDTH-1:0]         tx_data,
    // Status
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [7:0]               err_cnt
);

    localparam int c_ADDR_W = $clog2(DEPTH);
    localparam int c_LVL_W  = c_ADDR_W + 1;

    localparam logic [c_LVL_W-1:0]  c_FULL_LEVEL = c_LVL_W'(DEPTH);
    localparam logic [c_LVL_W-1:0]  c_LVL_ONE    = c_LVL_W'(1);
    localparam logic [c_ADDR_W-1:0] c_PTR_ONE    = c_ADDR_W'(1);
    localparam logic [7:0]          c_ERR_MAX    = 8'hFF;

    // The pointers wrap by natural binary overflow, which only matches the
    // array size when DEPTH is a power of two.
    generate
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
            $error("uart_rx_fifo: DEPTH must be a power of two and at least 2");
        end
    endgenerate

    // ------------------------------------------------------------------------
    //  Transmit-side state machine encoding
    // ------------------------------------------------------------------------
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,   // ready to launch the next byte
        ST_WAIT = 1'b1    // byte launched, waiting for uart_tx to finish
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;

    // ------------------------------------------------------------------------
    //  Storage and bookkeeping registers
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0]        r_mem [DEPTH];
    logic [c_ADDR_W-1:0]     r_wr_ptr;
    logic [c_ADDR_W-1:0]     r_rd_ptr;
    logic [c_LVL_W-1:0]      r_level;
    logic                    r_overflow;
    logic [7:0]              r_err_cnt;
    logic                    r_tx_start;
    logic [WIDTH-1:0]        r_tx_data;

    // ------------------------------------------------------------------------
    //  Combinational qualifiers
    // ------------------------------------------------------------------------
    logic                    w_full;
    logic                    w_not_empty;
    logic                    w_good_byte;
    logic                    w_launch;
    logic                    w_pop;
    logic                    w_push;
    logic                    w_drop;
    logic                    w_ferr;

    assign w_full      = (r_level == c_FULL_LEVEL);
    assign w_not_empty = (r_level != '0);

    // A pop is exactly a launch: bytes leave the FIFO only when handed to
    // uart_tx, so the FIFO can never underflow.
    assign w_pop       = w_launch;

    assign w_good_byte = rx_done & ~frame_error;
    // A full FIFO still accepts a byte on the edge that frees a slot.
    assign w_push      = w_good_byte & (~w_full | w_pop);
    assign w_drop      = w_good_byte & w_full & ~w_pop;
    assign w_ferr      = rx_done & frame_error;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state and launch decision
    always_comb begin
        w_state_nxt = r_state;
        w_launch    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_not_empty && !tx_busy) begin
                    w_launch    = 1'b1;
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A tx_done seen in IDLE (e.g. from a frame launched before
                // a reset) is simply ignored by the IDLE branch.
                if (tx_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Byte storage; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= rx_data;
        end
    end

    // Write/read pointers and occupancy tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_LVL_ONE;
                2'b01:   r_level <= r_level - c_LVL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

    // Launch register: one-cycle start pulse and held output byte.
    // When full with a simultaneous push, wr_ptr equals rd_ptr; the
    // non-blocking read below still returns the older stored byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_start <= 1'b0;
            r_tx_data  <= '0;
        end else begin
            r_tx_start <= w_launch;
            if (w_launch) begin
                r_tx_data <= r_mem[r_rd_ptr];
            end
        end
    end

    // Sticky overflow flag and saturating framing-error counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
            r_err_cnt  <= '0;
        end else begin
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_ferr && (r_err_cnt != c_ERR_MAX)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    assign tx_start = r_tx_start;
    assign tx_data  = r_tx_data;
    assign level    = r_level;
    assign overflow = r_overflow;
    assign err_cnt  = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_fifo
//  Description : Scoreboard bench for uart_rx_fifo. Stimulus pushes expected
//                transmit bytes into a queue; a monitor pops and compares on
//                every tx_start. A simple uart_tx model answers each launch
//                with 20 busy cycles followed by a tx_done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

    localparam int c_WIDTH = 8;
    localparam int c_DEPTH = 16;
    localparam int c_LVL_W = $clog2(c_DEPTH) + 1;

    logic                clk;
    logic                rst;
    logic [c_WIDTH-1:0]  rx_data;
    logic                rx_done;
    logic                frame_error;
    logic                tx_busy;
    logic                tx_done;
    logic                tx_start;
    logic [c_WIDTH-1:0]  tx_data;
    logic [c_LVL_W-1:0]  level;
    logic                overflow;
    logic [7:0]          err_cnt;

    logic                model_busy;
    logic                hold_busy;
    logic                model_active;
    logic                prev_start;

    int                  n_checks;
    int                  n_pass;
    int                  n_launch;
    int                  n_done;

    logic [c_WIDTH-1:0]  exp_q[$];

    assign tx_busy = model_busy | hold_busy;

    uart_rx_fifo #(
        .WIDTH (c_WIDTH),
        .DEPTH (c_DEPTH)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_done     (rx_done),
        .frame_error (frame_error),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .level       (level),
        .overflow    (overflow),
        .err_cnt     (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: bump the counters and report a mismatch
    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] required);
        n_checks++;
        if (actual === required) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, actual, required);
        end
    endtask

    // Drive one rx_done pulse; call right after a falling edge
    task automatic send(input logic [7:0] d, input logic fe, input logic expect_out);
        if (expect_out) begin
            exp_q.push_back(d);
        end
        rx_data     = d;
        frame_error = fe;
        rx_done     = 1'b1;
        @(negedge clk);
        rx_done     = 1'b0;
        frame_error = 1'b0;
    endtask

    // One-cycle reset pulse; queued bytes are discarded by the DUT
    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
    endtask

    // Wait until every expected byte has been sent and the TX model is idle
    task automatic wait_drain(input string name);
        int cnt;
        cnt = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || model_active || level != '0 || tx_done)
               && cnt < 3000) begin
            @(negedge clk);
            cnt++;
        end
        check({name, "_timeout"}, 32'(cnt >= 3000), 32'd0);
        check({name, "_level"}, 32'(level), 32'd0);
    endtask

    // Reset-value check of all outputs
    task automatic check_reset_vals(input string name);
        check({name, "_tx_start"}, 32'(tx_start), 32'd0);
        check({name, "_tx_data"},  32'(tx_data),  32'd0);
        check({name, "_level"},    32'(level),    32'd0);
        check({name, "_overflow"}, 32'(overflow), 32'd0);
        check({name, "_err_cnt"},  32'(err_cnt),  32'd0);
    endtask

    // Monitor: compare every launch against the scoreboard queue
    always @(negedge clk) begin
        if (tx_start) begin
            n_launch++;
            check("tx_start_one_cycle", 32'(prev_start), 32'd0);
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_tx_start: tx_data=0x%0h, required no launch", tx_data);
            end else begin
                check("tx_data_order", 32'(tx_data), 32'(exp_q.pop_front()));
            end
        end
        prev_start = tx_start;
    end

    // uart_tx model: 20 busy cycles per launch, then a one-cycle tx_done
    initial begin
        model_busy   = 1'b0;
        tx_done      = 1'b0;
        model_active = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start) begin
                model_active = 1'b1;
                model_busy   = 1'b1;
                repeat (20) @(negedge clk);
                model_busy = 1'b0;
                tx_done    = 1'b1;
                n_done++;
                @(negedge clk);
                tx_done      = 1'b0;
                model_active = 1'b0;
            end
        end
    end

    // Watchdog
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    // Directed stimulus
    initial begin
        int l0;
        int d0;
        n_checks    = 0;
        n_pass      = 0;
        n_launch    = 0;
        n_done      = 0;
        prev_start  = 1'b0;
        hold_busy   = 1'b0;
        rst         = 1'b1;
        rx_data     = '0;
        rx_done     = 1'b0;
        frame_error = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset_vals("reset");

        // Single byte: level 0->1->0, tx_start two cycles after rx_done
        @(negedge clk);
        send(8'h5A, 1'b0, 1'b1);
        check("single_level_after_push", 32'(level), 32'd1);
        check("single_no_early_start", 32'(tx_start), 32'd0);
        @(negedge clk);
        check("single_tx_start", 32'(tx_start), 32'd1);
        check("single_level_after_pop", 32'(level), 32'd0);
        @(negedge clk);
        check("single_start_dropped", 32'(tx_start), 32'd0);
        check("single_tx_data_held", 32'(tx_data), 32'h5A);
        wait_drain("single");

        // Burst ordering: 0x01..0x05 back to back
        l0 = n_launch;
        d0 = n_done;
        for (int i = 1; i <= 5; i++) begin
            send(8'(i), 1'b0, 1'b1);
        end
        wait_drain("burst");
        check("burst_launches", 32'(n_launch - l0), 32'd5);
        check("burst_done_per_start", 32'(n_done - d0), 32'd5);
        check("burst_overflow", 32'(overflow), 32'd0);

        // Overflow: DEPTH+2 bytes while the transmitter stays busy
        hold_busy = 1'b1;
        for (int i = 0; i < c_DEPTH; i++) begin
            send(8'(8'h10 + i), 1'b0, 1'b1);
        end
        check("ovf_level_full", 32'(level), 32'(c_DEPTH));
        check("ovf_not_yet", 32'(overflow), 32'd0);
        send(8'hE0, 1'b0, 1'b0);
        send(8'hE1, 1'b0, 1'b0);
        check("ovf_level_stays_full", 32'(level), 32'(c_DEPTH));
        check("ovf_flag_set", 32'(overflow), 32'd1);
        hold_busy = 1'b0;
        wait_drain("ovf");
        check("ovf_flag_sticky", 32'(overflow), 32'd1);

        // Framing errors interleaved with two good bytes
        do_reset();
        send(8'hFF, 1'b1, 1'b0);
        send(8'hA1, 1'b0, 1'b1);
        send(8'hEE, 1'b1, 1'b0);
        send(8'hA2, 1'b0, 1'b1);
        send(8'hDD, 1'b1, 1'b0);
        wait_drain("ferr");
        check("ferr_count3", 32'(err_cnt), 32'd3);
        for (int i = 0; i < 260; i++) begin
            send(8'(i), 1'b1, 1'b0);
        end
        check("ferr_saturate", 32'(err_cnt), 32'd255);
        check("ferr_nothing_stored", 32'(level), 32'd0);

        // Full FIFO with push aligned to a launch edge
        do_reset();
        hold_busy = 1'b1;
        for (int i = 0; i < c_DEPTH; i++) begin
            send(8'(8'h30 + i), 1'b0, 1'b1);
        end
        check("fullpop_level_before", 32'(level), 32'(c_DEPTH));
        hold_busy = 1'b0;
        send(8'h77, 1'b0, 1'b1);
        check("fullpop_launch", 32'(tx_start), 32'd1);
        check("fullpop_level_kept", 32'(level), 32'(c_DEPTH));
        check("fullpop_no_overflow", 32'(overflow), 32'd0);
        wait_drain("fullpop");

        // Reset while a frame is in flight with 4 bytes queued
        do_reset();
        hold_busy = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            send(8'(8'h40 + i), 1'b0, 1'b1);
        end
        check("midrst_level5", 32'(level), 32'd5);
        hold_busy = 1'b0;
        @(negedge clk);
        check("midrst_launch", 32'(tx_start), 32'd1);
        check("midrst_level4", 32'(level), 32'd4);
        do_reset();
        check_reset_vals("midrst");
        l0 = n_launch;
        repeat (60) @(negedge clk);
        check("midrst_no_launch", 32'(n_launch - l0), 32'd0);
        check("midrst_level_zero", 32'(level), 32'd0);
        check("midrst_tx_data_zero", 32'(tx_data), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
